pmem_arbiter: RTL
=================

# pmem_arbiter

Two-requester arbiter and sequencer for the single-port 16-bit program RAM. It shares the RAM between the pipelined CPU's data-memory port (memory stage) and a debug/loader port. It drives the RAM address, write data and write strobe, and sequences the fixed read wait. Each requester gets a one-cycle grant pulse and, for reads, a one-cycle response pulse with the captured data.

## Interface
- DATA_W, 16, RAM data width
- ADDR_W, 16, RAM address width
- RD_LATENCY, 2, cycles the RAM address must be held before mem_rdata is valid; legal range 1..7
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle accept pulse
- cpu_rvalid  out  1  one-cycle read-data-valid pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_rvalid
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* set, for the debug/loader port
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write strobe
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, WAIT, RESP. One transaction is in flight at a time.
- IDLE: the arbiter samples both req lines on each clock edge.
  - With no request, it stays in IDLE.
  - Otherwise it picks a winner, registers the winner's addr/wdata/we into mem_addr/mem_wdata/an internal we flag, latches the owner, and moves to ACCESS.
- ACCESS: the winner's gnt is 1 for exactly this cycle. mem_we equals the latched we for exactly this cycle.
  - Write: next state is IDLE.
  - Read with RD_LATENCY=1: the arbiter captures mem_rdata at the end of this cycle and moves to RESP.
  - Read with RD_LATENCY>1: it loads the wait counter with RD_LATENCY-2 and moves to WAIT.
- WAIT: mem_addr is held and the counter decrements. When the counter reaches 0, the arbiter captures mem_rdata into the owner's rdata register and moves to RESP.
- RESP: the owner's rvalid is 1 for one cycle with rdata stable. Next state is IDLE.
- Requests are sampled only in IDLE. A req still high during ACCESS/WAIT/RESP is ignored. A requester must drop req, or present a new request, by the cycle after its gnt.
- Each rdata holds its last captured value until the next read by the same owner. The non-owner's rvalid stays 0.
- Arbitration when both requesters ask at once is set by the macro in Configuration. A single requester always wins.
- mem_addr and mem_wdata hold their last value in IDLE. mem_we is 0 outside ACCESS.

## Timing
- Reset: state=IDLE, all outputs 0 (gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, busy), counter=0, last-winner=dbg.
- Reset asserted mid-transaction aborts it: no gnt or rvalid is issued after reset release, and the request must be re-issued.
- Define edge E0 as the edge where IDLE samples req. Then:
  - gnt and the mem_* outputs are valid in cycle E0+1.
  - Write: back in IDLE at E0+2, so sustained write throughput is 1 per 2 cycles.
  - Read: rvalid in cycle E0+RD_LATENCY+1, and IDLE at E0+RD_LATENCY+2.
- mem_rdata must be valid in the RD_LATENCY-th cycle of address presentation. It is sampled on the edge that ends that cycle.
- Counter width is 3 bits. RD_LATENCY values outside 1..7 are a synthesis error, enforced by a generate-time check.

## Configuration
- PMEM_ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the requester that did not win last is granted. Last-winner updates on every grant.
- PMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU always wins a tie, and the last-winner register is not built. A continuous cpu_req may starve dbg; this is accepted.

## Structure
- The shared package plncpu_pkg holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP, 2 bits)
  - requester index constants OWNER_CPU=0 and OWNER_DBG=1
  - default widths
- The winner-select logic lives in one combinational sub-module, pmem_arb_pick. Its inputs are cpu_req, dbg_req and last_winner; its outputs are grant_valid and owner.
- Everything else is in pmem_arbiter.

## Test plan
- Reset: hold rst_n=0 with both reqs high → all outputs 0. Release reset → cpu_gnt in the first ACCESS cycle.
- CPU write: addr=0x0010, wdata=0xBEEF → cpu_gnt=1 and mem_we=1 with mem_addr=0x0010 and mem_wdata=0xBEEF in cycle E0+1 only. No cpu_rvalid. busy is low at E0+2.
- dbg read with RD_LATENCY=2: RAM returns 0x1234 for addr 0x0020 → dbg_gnt at E0+1, dbg_rvalid=1 with dbg_rdata=0x1234 at E0+3, cpu_rvalid stays 0.
- Simultaneous requests, three back-to-back pairs: with the macro, grant order is cpu, dbg, cpu. Without the macro, the order is cpu, cpu, cpu.
- Reset pulse during WAIT of a cpu read: no cpu_rvalid afterwards, state=IDLE, and mem_we=0 throughout.
- A req held high through ACCESS/WAIT/RESP produces exactly one gnt per IDLE sampling. No duplicate grant is issued inside a transaction.

Source files
------------

// File: rtl/plncpu_pkg.sv
// Shared types and constants for the program-memory arbiter (pmem_arbiter).
package plncpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } pmem_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the two requester ports and the RAM port around pmem_arbiter.
// slave is the arbiter's view; master is the requester/RAM side.
interface pmem_arbiter_if
    import plncpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_wdata, mem_we, busy
    );

endinterface

// File: rtl/pmem_arb_pick.sv
// Combinational winner select for pmem_arbiter.
// PMEM_ARB_ROUND_ROBIN_EN: ties go to the requester that did not win last; otherwise CPU wins ties.
module pmem_arb_pick
    import plncpu_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_winner,
    output logic grant_valid,
    output logic owner
);

    assign grant_valid = cpu_req | dbg_req;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        owner = cpu_req ? OWNER_CPU : OWNER_DBG;
        if (cpu_req && dbg_req) begin
            owner = (last_winner == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
        end
    end
`else
    // Fixed priority has no history; last_winner is intentionally ignored.
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
    assign owner = cpu_req ? OWNER_CPU : OWNER_DBG;
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port program RAM with a fixed read wait.
// Optional macro PMEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: CPU priority).
module pmem_arbiter
    import plncpu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RD_LATENCY = 2
)
(
    input  logic          clk,
    input  logic          rst_n,
    pmem_arbiter_if.slave bus
);

    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
        $error("pmem_arbiter: RD_LATENCY must be in 1..7");
    end

    // ACCESS already counts as the first cycle of address presentation.
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        (RD_LATENCY >= 2) ? WAIT_CNT_W'(RD_LATENCY - 2) : '0;

    pmem_state_t             state_q;
    logic                    owner_q;
    logic                    we_q;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;
    logic                    mem_we_q;
    logic                    cpu_gnt_q, dbg_gnt_q;
    logic                    cpu_rvalid_q, dbg_rvalid_q;
    logic [DATA_W-1:0]       cpu_rdata_q, dbg_rdata_q;
    logic                    busy_q;

    logic                    grant_valid_d;
    logic                    owner_d;
    logic                    last_winner;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    logic last_winner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner_q <= OWNER_DBG;
        end else if (state_q == IDLE && grant_valid_d) begin
            last_winner_q <= owner_d;
        end
    end

    assign last_winner = last_winner_q;
`else
    assign last_winner = OWNER_DBG;
`endif

    pmem_arb_pick u_pick (
        .cpu_req     (bus.cpu_req),
        .dbg_req     (bus.dbg_req),
        .last_winner (last_winner),
        .grant_valid (grant_valid_d),
        .owner       (owner_d)
    );

    assign sel_we    = (owner_d == OWNER_CPU) ? bus.cpu_we    : bus.dbg_we;
    assign sel_addr  = (owner_d == OWNER_CPU) ? bus.cpu_addr  : bus.dbg_addr;
    assign sel_wdata = (owner_d == OWNER_CPU) ? bus.cpu_wdata : bus.dbg_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_CPU;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            // Pulse outputs default low; only the transition that owns them raises them.
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        owner_q     <= owner_d;
                        we_q        <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_we_q    <= sel_we;
                        cpu_gnt_q   <= (owner_d == OWNER_CPU);
                        dbg_gnt_q   <= (owner_d == OWNER_DBG);
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (RD_LATENCY == 1) begin
                        if (owner_q == OWNER_CPU) begin
                            cpu_rdata_q  <= bus.mem_rdata;
                            cpu_rvalid_q <= 1'b1;
                        end else begin
                            dbg_rdata_q  <= bus.mem_rdata;
                            dbg_rvalid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= WAIT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (owner_q == OWNER_CPU) begin
                            cpu_rdata_q  <= bus.mem_rdata;
                            cpu_rvalid_q <= 1'b1;
                        end else begin
                            dbg_rdata_q  <= bus.mem_rdata;
                            dbg_rvalid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dbg_gnt    = dbg_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.busy       = busy_q;

endmodule
